// File: rtl/sdram_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : sdram_port_arbiter
//  Description : Three-master arbiter in front of a single-port SDRAM
//                controller. Port 0 (video scan-out) has fixed priority
//                bounded by a starvation guard. Ports 1 (CPU) and 2
//                (graphics) share the remaining slots round-robin. Only one
//                memory transaction is outstanding at any time.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdram_port_arbiter #(
    parameter int ADDR_W       = 24,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                       clk_sdram,
    input  logic                       reset_n_i,
    // Master side
    input  logic [2:0]                 req_i,
    input  logic [2:0]                 we_i,
    input  logic [3*ADDR_W-1:0]        addr_i,
    input  logic [3*DATA_W-1:0]        wdata_i,
    input  logic [3*(DATA_W/8)-1:0]    wmask_i,
    output logic [2:0]                 ack_o,
    output logic [2:0]                 rvalid_o,
    output logic [DATA_W-1:0]          rdata_o,
    output logic                       busy_o,
    // SDRAM controller side
    output logic                       mem_req_o,
    output logic                       mem_we_o,
    output logic [ADDR_W-1:0]          mem_addr_o,
    output logic [DATA_W-1:0]          mem_wdata_o,
    output logic [(DATA_W/8)-1:0]      mem_wmask_o,
    input  logic                       mem_ack_i,
    input  logic                       mem_rvalid_i,
    input  logic [DATA_W-1:0]          mem_rdata_i
);

    localparam int c_MASK_W = DATA_W / 8;
    localparam int c_CNT_W  = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CMD    = 2'd1,
        ST_RDWAIT = 2'd2
    } state_t;

    state_t                r_state;
    logic [1:0]            r_owner;
    // 0: port 1 is preferred next, 1: port 2 is preferred next
    logic                  r_rr_ptr;
    logic [c_CNT_W-1:0]    r_starve_cnt;
    logic                  r_busy;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [ADDR_W-1:0]     r_mem_addr;
    logic [DATA_W-1:0]     r_mem_wdata;
    logic [c_MASK_W-1:0]   r_mem_wmask;
    logic [2:0]            r_rvalid;
    logic [DATA_W-1:0]     r_rdata;

    logic                  w_any_req;
    logic                  w_low_req;
    logic                  w_starved;
    logic [1:0]            w_rr_winner;
    logic [1:0]            w_winner;
    logic                  w_sel_we;
    logic [ADDR_W-1:0]     w_sel_addr;
    logic [DATA_W-1:0]     w_sel_wdata;
    logic [c_MASK_W-1:0]   w_sel_wmask;
    logic [2:0]            w_owner_oh;

    // Winner selection: starvation guard first, then video, then round-robin.
    always_comb begin
        w_any_req = |req_i;
        w_low_req = req_i[1] | req_i[2];
        w_starved = (r_starve_cnt == c_LIMIT) && w_low_req;
        if (!r_rr_ptr) begin
            w_rr_winner = req_i[1] ? 2'd1 : 2'd2;
        end else begin
            w_rr_winner = req_i[2] ? 2'd2 : 2'd1;
        end
        if (w_starved) begin
            w_winner = w_rr_winner;
        end else if (req_i[0]) begin
            w_winner = 2'd0;
        end else begin
            w_winner = w_rr_winner;
        end
    end

    // Payload multiplexer for the selected port.
    always_comb begin
        w_sel_we    = we_i[0];
        w_sel_addr  = addr_i[0 +: ADDR_W];
        w_sel_wdata = wdata_i[0 +: DATA_W];
        w_sel_wmask = wmask_i[0 +: c_MASK_W];
        case (w_winner)
            2'd1: begin
                w_sel_we    = we_i[1];
                w_sel_addr  = addr_i[ADDR_W +: ADDR_W];
                w_sel_wdata = wdata_i[DATA_W +: DATA_W];
                w_sel_wmask = wmask_i[c_MASK_W +: c_MASK_W];
            end
            2'd2: begin
                w_sel_we    = we_i[2];
                w_sel_addr  = addr_i[2*ADDR_W +: ADDR_W];
                w_sel_wdata = wdata_i[2*DATA_W +: DATA_W];
                w_sel_wmask = wmask_i[2*c_MASK_W +: c_MASK_W];
            end
            default: begin
            end
        endcase
    end

    // Owner one-hot and the combinational acknowledge back to the owner.
    always_comb begin
        w_owner_oh = 3'b001 << r_owner;
        ack_o      = ((r_state == ST_CMD) && mem_ack_i) ? w_owner_oh : 3'b000;
    end

    // Arbitration, command hand-off to the controller and read-data return.
    always_ff @(posedge clk_sdram or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state      <= ST_IDLE;
            r_owner      <= 2'd0;
            r_rr_ptr     <= 1'b0;
            r_starve_cnt <= '0;
            r_busy       <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_wmask  <= '0;
            r_rvalid     <= 3'b000;
            r_rdata      <= '0;
        end else begin
            r_rvalid <= 3'b000;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_owner     <= w_winner;
                        r_mem_we    <= w_sel_we;
                        r_mem_addr  <= w_sel_addr;
                        r_mem_wdata <= w_sel_wdata;
                        r_mem_wmask <= w_sel_wmask;
                        r_mem_req   <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ST_CMD;
                        if (w_winner == 2'd0) begin
                            // Video only counts toward starvation while others wait.
                            if (w_low_req) begin
                                if (r_starve_cnt != c_LIMIT) begin
                                    r_starve_cnt <= r_starve_cnt + c_CNT_W'(1);
                                end
                            end else begin
                                r_starve_cnt <= '0;
                            end
                        end else begin
                            r_starve_cnt <= '0;
                            r_rr_ptr     <= (w_winner == 2'd1);
                        end
                    end
                end
                ST_CMD: begin
                    if (mem_ack_i) begin
                        r_mem_req <= 1'b0;
                        if (r_mem_we) begin
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else if (mem_rvalid_i) begin
                            // Controller returned data in the accept cycle.
                            r_rdata  <= mem_rdata_i;
                            r_rvalid <= w_owner_oh;
                            r_busy   <= 1'b0;
                            r_state  <= ST_IDLE;
                        end else begin
                            r_state <= ST_RDWAIT;
                        end
                    end
                end
                ST_RDWAIT: begin
                    if (mem_rvalid_i) begin
                        r_rdata  <= mem_rdata_i;
                        r_rvalid <= w_owner_oh;
                        r_busy   <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rvalid_o    = r_rvalid;
    assign rdata_o     = r_rdata;
    assign busy_o      = r_busy;
    assign mem_req_o   = r_mem_req;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;
    assign mem_wmask_o = r_mem_wmask;

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_sdram_port_arbiter
//  Description : Self-checking bench for sdram_port_arbiter: directed vector
//                table, multi-cycle corner sequences and randomized traffic
//                against a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_port_arbiter;

    localparam int AW = 24;
    localparam int DW = 32;
    localparam int MW = DW / 8;
    localparam int SL = 8;

    logic                clk = 1'b0;
    logic                reset_n_i;
    logic [2:0]          req_i;
    logic [2:0]          we_i;
    logic [3*AW-1:0]     addr_i;
    logic [3*DW-1:0]     wdata_i;
    logic [3*MW-1:0]     wmask_i;
    logic [2:0]          ack_o;
    logic [2:0]          rvalid_o;
    logic [DW-1:0]       rdata_o;
    logic                busy_o;
    logic                mem_req_o;
    logic                mem_we_o;
    logic [AW-1:0]       mem_addr_o;
    logic [DW-1:0]       mem_wdata_o;
    logic [MW-1:0]       mem_wmask_o;
    logic                mem_ack_i;
    logic                mem_rvalid_i;
    logic [DW-1:0]       mem_rdata_i;

    sdram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)) dut (
        .clk_sdram    (clk),
        .reset_n_i    (reset_n_i),
        .req_i        (req_i),
        .we_i         (we_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .wmask_i      (wmask_i),
        .ack_o        (ack_o),
        .rvalid_o     (rvalid_o),
        .rdata_o      (rdata_o),
        .busy_o       (busy_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_wmask_o  (mem_wmask_o),
        .mem_ack_i    (mem_ack_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Master-side state, one entry per port
    logic [2:0]   pend;
    logic         p_we    [3];
    logic [AW-1:0] p_addr [3];
    logic [DW-1:0] p_wdata[3];
    logic [MW-1:0] p_wmask[3];

    // Reference model of the arbitration policy
    int rr_next;   // port (1 or 2) preferred next among the low-priority pair
    int streak;    // consecutive video grants while port 1/2 waited, capped

    logic [DW-1:0] last_rdata;

    typedef struct {
        logic [2:0]    req;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [MW-1:0] wmask;
        int            ack_dly;
        int            rv_dly;    // 0 = data returned together with accept
        logic [DW-1:0] rdata;
        int            exp_owner;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] oh(input int k);
        oh = 3'b001 << k;
    endfunction

    task automatic drive_bus();
        for (int k = 0; k < 3; k++) begin
            req_i[k]             = pend[k];
            we_i[k]              = p_we[k];
            addr_i[k*AW +: AW]   = p_addr[k];
            wdata_i[k*DW +: DW]  = p_wdata[k];
            wmask_i[k*MW +: MW]  = p_wmask[k];
        end
    endtask

    function automatic int pick(input logic [2:0] r);
        int rr_w;
        rr_w = r[rr_next] ? rr_next : (3 - rr_next);
        if (streak == SL && (r[1] || r[2])) pick = rr_w;
        else if (r[0])                      pick = 0;
        else                                pick = rr_w;
    endfunction

    task automatic model_grant(input int w, input logic [2:0] r);
        if (w == 0) begin
            if (r[1] || r[2]) streak = (streak < SL) ? streak + 1 : SL;
            else              streak = 0;
        end else begin
            streak  = 0;
            rr_next = (w == 1) ? 2 : 1;
        end
    endtask

    task automatic do_reset();
        reset_n_i = 1'b0;
        tick();
        tick();
        reset_n_i = 1'b1;
        rr_next = 1;
        streak  = 0;
        last_rdata = '0;
    endtask

    // One directed transaction from an idle arbiter
    task automatic run_vec(input vec_t v, input int idx);
        logic coinc;
        string tag;
        tag = $sformatf("vec%0d", idx);
        for (int k = 0; k < 3; k++) begin
            p_we[k]    = v.we;
            p_addr[k]  = (k == v.exp_owner) ? v.addr  : ~v.addr;
            p_wdata[k] = (k == v.exp_owner) ? v.wdata : ~v.wdata;
            p_wmask[k] = (k == v.exp_owner) ? v.wmask : ~v.wmask;
        end
        pend = v.req;
        mem_ack_i = 1'b0;
        mem_rvalid_i = 1'b0;
        drive_bus();
        tick();
        chk({tag, "_mem_req"}, mem_req_o, 1);
        chk({tag, "_busy"},    busy_o, 1);
        chk({tag, "_addr"},    mem_addr_o, v.addr);
        chk({tag, "_we"},      mem_we_o, v.we);
        chk({tag, "_wdata"},   mem_wdata_o, v.wdata);
        chk({tag, "_wmask"},   mem_wmask_o, v.wmask);
        repeat (v.ack_dly) tick();
        chk({tag, "_hold"}, {mem_req_o, mem_addr_o}, {1'b1, v.addr});
        coinc = !v.we && (v.rv_dly == 0);
        mem_ack_i = 1'b1;
        if (coinc) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = v.rdata;
        end
        #1;
        chk({tag, "_ack"}, ack_o, oh(v.exp_owner));
        tick();
        mem_ack_i = 1'b0;
        mem_rvalid_i = 1'b0;
        pend = 3'b000;
        drive_bus();
        chk({tag, "_req_drop"}, mem_req_o, 0);
        chk({tag, "_ack_pulse"}, ack_o, 0);
        if (v.we) begin
            chk({tag, "_wr_busy"},   busy_o, 0);
            chk({tag, "_wr_rvalid"}, rvalid_o, 0);
            chk({tag, "_rdata_hold"}, rdata_o, last_rdata);
        end else if (coinc) begin
            chk({tag, "_co_rvalid"}, rvalid_o, oh(v.exp_owner));
            chk({tag, "_co_rdata"},  rdata_o, v.rdata);
            chk({tag, "_co_busy"},   busy_o, 0);
            last_rdata = v.rdata;
        end else begin
            chk({tag, "_rd_busy"},   busy_o, 1);
            chk({tag, "_rd_early"},  rvalid_o, 0);
            repeat (v.rv_dly - 1) tick();
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = v.rdata;
            tick();
            mem_rvalid_i = 1'b0;
            chk({tag, "_rvalid"}, rvalid_o, oh(v.exp_owner));
            chk({tag, "_rdata"},  rdata_o, v.rdata);
            chk({tag, "_done_busy"}, busy_o, 0);
            last_rdata = v.rdata;
        end
        tick();
        chk({tag, "_rvalid_pulse"}, rvalid_o, 0);
    endtask

    // Hold requests continuously, ack every command at once, record owners
    task automatic serve(input logic [2:0] r, input int n, input string tag, output int seq[32]);
        int waited;
        for (int k = 0; k < 3; k++) begin
            p_we[k] = 1'b1; p_addr[k] = AW'(k); p_wdata[k] = '0; p_wmask[k] = '1;
        end
        pend = r;
        drive_bus();
        for (int i = 0; i < n; i++) begin
            seq[i] = -1;
            waited = 0;
            while (mem_req_o !== 1'b1 && waited < 10) begin
                tick();
                waited++;
            end
            if (mem_req_o !== 1'b1) begin
                chk({tag, "_timeout"}, 0, 1);
                break;
            end
            seq[i] = int'(mem_addr_o);
            mem_ack_i = 1'b1;
            tick();
            mem_ack_i = 1'b0;
        end
        pend = 3'b000;
        drive_bus();
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int seq[32];
        int phase, cur, owner, w;
        logic owner_we, granted, exp_rv, ack, rv;
        logic [AW-1:0] g_addr;
        logic [DW-1:0] g_wdata, exp_rdata, rd;
        logic [MW-1:0] g_wmask;
        logic g_we;
        int prob[3];

        tbl[0] = '{3'b010, 1'b0, 24'h000100, 32'h0,        4'h0,    3, 5, 32'hDEADBEEF, 1};
        tbl[1] = '{3'b100, 1'b1, 24'h00ABCD, 32'h12345678, 4'b0011, 1, 0, 32'h0,        2};
        tbl[2] = '{3'b110, 1'b0, 24'h123456, 32'h0,        4'hF,    0, 1, 32'hCAFEF00D, 1};
        tbl[3] = '{3'b110, 1'b1, 24'h654321, 32'hA5A5A5A5, 4'b1000, 2, 0, 32'h0,        2};
        tbl[4] = '{3'b111, 1'b0, 24'hFFFFFF, 32'h0,        4'h1,    1, 2, 32'h0BADC0DE, 0};
        tbl[5] = '{3'b101, 1'b1, 24'h000000, 32'hFFFFFFFF, 4'hF,    0, 0, 32'h0,        0};
        tbl[6] = '{3'b100, 1'b0, 24'h0F0F0F, 32'h0,        4'h5,    2, 3, 32'h13579BDF, 2};
        tbl[7] = '{3'b010, 1'b1, 24'h800001, 32'h01020304, 4'b0110, 1, 0, 32'h0,        1};
        tbl[8] = '{3'b001, 1'b0, 24'h3C3C3C, 32'h0,        4'h0,    0, 4, 32'h2468ACE0, 0};
        tbl[9] = '{3'b011, 1'b0, 24'h777777, 32'h0,        4'hA,    2, 0, 32'hFEEDFACE, 0};

        pend = 3'b000;
        for (int k = 0; k < 3; k++) begin
            p_we[k] = 1'b0; p_addr[k] = '0; p_wdata[k] = '0; p_wmask[k] = '0;
        end
        drive_bus();
        mem_ack_i = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i = '0;
        reset_n_i = 1'b0;
        #22;
        chk("rst_ack",    ack_o, 0);
        chk("rst_rvalid", rvalid_o, 0);
        chk("rst_rdata",  rdata_o, 0);
        chk("rst_busy",   busy_o, 0);
        chk("rst_memreq", mem_req_o, 0);
        chk("rst_memwe",  mem_we_o, 0);
        chk("rst_addr",   mem_addr_o, 0);
        chk("rst_wdata",  mem_wdata_o, 0);
        chk("rst_wmask",  mem_wmask_o, 0);
        do_reset();

        // Directed vector table
        for (int i = 0; i < 10; i++) run_vec(tbl[i], i);

        // Ports 1 and 2 continuously after reset: strict alternation from port 1
        do_reset();
        serve(3'b110, 4, "alt", seq);
        for (int i = 0; i < 4; i++) chk($sformatf("alt_grant%0d", i), seq[i], (i % 2 == 0) ? 1 : 2);

        // Ports 0 and 1 continuously: STARVE_LIMIT video grants then one CPU grant
        serve(3'b011, 18, "starve", seq);
        for (int i = 0; i < 18; i++) chk($sformatf("starve_grant%0d", i), seq[i], (i % 9 == 8) ? 1 : 0);

        // Reset while waiting for read data
        pend = 3'b010; p_we[1] = 1'b0; p_addr[1] = 24'h000111;
        drive_bus();
        tick();
        chk("rdw_req", mem_req_o, 1);
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        pend = 3'b100; p_we[2] = 1'b1; p_addr[2] = 24'h000222; p_wdata[2] = 32'h55AA55AA; p_wmask[2] = 4'hF;
        drive_bus();
        chk("rdw_busy", busy_o, 1);
        #2;
        reset_n_i = 1'b0;
        #1;
        chk("rdw_rst_busy",   busy_o, 0);
        chk("rdw_rst_memreq", mem_req_o, 0);
        chk("rdw_rst_addr",   mem_addr_o, 0);
        chk("rdw_rst_rvalid", rvalid_o, 0);
        chk("rdw_rst_ack",    ack_o, 0);
        tick();
        tick();
        reset_n_i = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i = 32'h99999999;
        tick();
        mem_rvalid_i = 1'b0;
        chk("rdw_late_rvalid", rvalid_o, 0);
        chk("rdw_p2_req",  mem_req_o, 1);
        chk("rdw_p2_addr", mem_addr_o, 24'h000222);
        mem_ack_i = 1'b1;
        #1;
        chk("rdw_p2_ack", ack_o, 3'b100);
        tick();
        mem_ack_i = 1'b0;
        pend = 3'b000;
        drive_bus();
        chk("rdw_p2_busy", busy_o, 0);
        chk("rdw_rdata", rdata_o, 0);

        // Randomized traffic against the reference model
        do_reset();
        rr_next = 1; streak = 0;
        phase = 0; owner = 0; owner_we = 1'b0; granted = 1'b0; exp_rv = 1'b0;
        exp_rdata = '0; g_addr = '0; g_wdata = '0; g_wmask = '0; g_we = 1'b0;
        prob[0] = 70; prob[1] = 40; prob[2] = 40;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            tick();
            chk("rnd_mem_req", mem_req_o, (phase == 1));
            chk("rnd_busy",    busy_o, (phase != 0));
            if (granted) begin
                chk("rnd_addr",  mem_addr_o, g_addr);
                chk("rnd_we",    mem_we_o, g_we);
                chk("rnd_wdata", mem_wdata_o, g_wdata);
                chk("rnd_wmask", mem_wmask_o, g_wmask);
                granted = 1'b0;
            end
            chk("rnd_rvalid", rvalid_o, exp_rv ? oh(owner) : 3'b000);
            if (exp_rv) chk("rnd_rdata", rdata_o, exp_rdata);
            exp_rv = 1'b0;
            cur = phase;
            for (int k = 0; k < 3; k++) begin
                if (!pend[k] && $urandom_range(99) < prob[k]) begin
                    pend[k]    = 1'b1;
                    p_we[k]    = $urandom_range(1);
                    p_addr[k]  = AW'($urandom);
                    p_wdata[k] = $urandom;
                    p_wmask[k] = MW'($urandom);
                end
            end
            drive_bus();
            ack = 1'b0;
            rv  = 1'b0;
            rd  = $urandom;
            case (cur)
                0: begin
                    ack = ($urandom_range(7) == 0);
                    rv  = ($urandom_range(7) == 0);
                    if (pend != 3'b000) begin
                        w = pick(pend);
                        model_grant(w, pend);
                        owner = w; owner_we = p_we[w];
                        g_we = p_we[w]; g_addr = p_addr[w]; g_wdata = p_wdata[w]; g_wmask = p_wmask[w];
                        granted = 1'b1;
                        phase = 1;
                    end
                end
                1: begin
                    if ($urandom_range(2) == 0) begin
                        ack = 1'b1;
                        pend[owner] = 1'b0;
                        if (owner_we) begin
                            phase = 0;
                        end else if ($urandom_range(3) == 0) begin
                            rv = 1'b1; exp_rv = 1'b1; exp_rdata = rd; phase = 0;
                        end else begin
                            phase = 2;
                        end
                    end
                end
                default: begin
                    ack = ($urandom_range(7) == 0);
                    if ($urandom_range(2) == 0) begin
                        rv = 1'b1; exp_rv = 1'b1; exp_rdata = rd; phase = 0;
                    end
                end
            endcase
            mem_ack_i    = ack;
            mem_rvalid_i = rv;
            mem_rdata_i  = rd;
            #1;
            chk("rnd_ack", ack_o, (cur == 1 && ack) ? oh(owner) : 3'b000);
        end
        mem_ack_i = 1'b0;
        mem_rvalid_i = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single-port SDRAM controller in the SoC between three masters: video scan-out (port 0), CPU (port 1) and graphics engine (port 2).
- Sits in the clk_sdram domain between the masters' clock-crossing FIFOs and the SDRAM controller.
- Video has fixed top priority, with a starvation guard. CPU and graphics share the remaining slots round-robin.
- Exactly one outstanding memory transaction at a time.

Parameters:
ADDR_W, 24, word address width toward SDRAM controller
DATA_W, 32, data width
STARVE_LIMIT, 8, consecutive video grants allowed while port 1 or 2 is pending (>=1)

Ports:
clk_sdram  input  1  SDRAM-domain clock (100 MHz)
reset_n_i  input  1  asynchronous active-low reset
req_i  input  3  per-port request, bit k = port k
we_i  input  3  per-port write enable (1=write, 0=read)
addr_i  input  3*ADDR_W  per-port address, port k at [k*ADDR_W +: ADDR_W]
wdata_i  input  3*DATA_W  per-port write data
wmask_i  input  3*(DATA_W/8)  per-port byte enables
ack_o  output  3  one-cycle pulse: port k command accepted by SDRAM controller
rvalid_o  output  3  one-cycle pulse: read data for port k valid on rdata_o
rdata_o  output  DATA_W  read data, shared by all ports
busy_o  output  1  transaction in flight
mem_req_o  output  1  command request to SDRAM controller
mem_we_o  output  1  command is a write
mem_addr_o  output  ADDR_W  command address
mem_wdata_o  output  DATA_W  write data
mem_wmask_o  output  DATA_W/8  byte enables
mem_ack_i  input  1  controller accepted command (single-cycle)
mem_rvalid_i  input  1  controller read data valid (single-cycle)
mem_rdata_i  input  DATA_W  controller read data

Behaviour:
- Reset (reset_n_i low, asynchronous):
  - All outputs 0; state IDLE.
  - Round-robin pointer = port 1; starvation counter = 0.
  - Reset mid-transaction abandons it silently: no ack_o/rvalid_o, and late mem_rvalid_i after reset is ignored.
- States: IDLE, CMD, RDWAIT.
- IDLE, when any req_i bit is set:
  - Select winner; latch owner index, we, addr, wdata, wmask into mem_* registers.
  - Set mem_req_o=1 and busy_o=1 on the next edge. Go to CMD.
  - Request-to-mem_req_o latency is 1 cycle.
- Winner selection:
  - If starvation counter == STARVE_LIMIT and port 1 or 2 requests, the round-robin winner of ports 1/2 is chosen.
  - Else port 0, if requesting.
  - Else the round-robin winner among ports 1/2: pointer port first if requesting, otherwise the other.
  - After a port 1/2 grant, the pointer moves to the other port.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) on each port-0 grant while req_i[1] or req_i[2] is high.
  - Clears on any port 1/2 grant.
  - Clears on a port-0 grant with ports 1/2 idle.
- CMD:
  - mem_* held stable until mem_ack_i.
  - On mem_ack_i: ack_o[owner] pulses the same cycle (combinational from mem_ack_i and owner) and mem_req_o drops next edge.
  - Write: go to IDLE, busy_o clears.
  - Read: go to RDWAIT.
  - If mem_rvalid_i coincides with mem_ack_i on a read, complete immediately as in RDWAIT.
- RDWAIT:
  - On mem_rvalid_i: rdata_o <= mem_rdata_i and rvalid_o[owner] <= 1 (registered, 1-cycle pulse); go to IDLE.
  - rdata_o holds its value until the next read completes.
- Back-to-back: the IDLE cycle after completion arbitrates, so minimum spacing between commands is 2 cycles (IDLE + CMD).
- Request handshake:
  - Masters hold req_i and payload until ack_o.
  - The payload is captured at grant, so changes after grant are ignored.
  - A request dropped before ack is still executed and acked.
- Spurious signals: mem_ack_i outside CMD and mem_rvalid_i outside CMD/RDWAIT are ignored.
- ack_o and rvalid_o are at most one-hot.

Test Plan:
- Single CPU read, addr 0x000100:
  - mem_req_o rises 1 cycle after req_i[1]; mem_addr_o=0x000100, mem_we_o=0.
  - ack after 3 cycles -> ack_o=3'b010 pulse.
  - mem_rvalid_i with 0xDEADBEEF 5 cycles later -> rvalid_o=3'b010 for 1 cycle, rdata_o=0xDEADBEEF.
- GPU write, addr 0x00ABCD, data 0x12345678, mask 4'b0011:
  - mem_* carry exactly those values.
  - ack_o=3'b100; busy_o clears the next cycle; no rvalid_o.
- Ports 1 and 2 requesting continuously, port 0 idle -> grants alternate 1,2,1,2 starting with port 1 after reset.
- Ports 0 and 1 requesting continuously, STARVE_LIMIT=8 -> 8 port-0 grants, 1 port-1 grant, repeating.
- Simultaneous mem_ack_i and mem_rvalid_i on a read -> ack_o and rvalid_o pulse for the owner, with no RDWAIT cycle.
- reset_n_i asserted in RDWAIT:
  - Outputs 0 immediately (asynchronous); mem_rvalid_i after release produces no rvalid_o.
  - A pending port-2 request is then granted normally.
